// File: rtl/aes_cbc_stream_seq.sv
// Streaming valid/ready front-end for aes_core: key setup, one block in flight, CBC chaining per message.
// Optional block counter port blk_cnt is enabled by defining AES_SEQ_BLKCNT_EN.
module aes_cbc_stream_seq #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_W           = 10
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         cfg_start,
    input  logic         cfg_encdec,
    input  logic         cfg_ecb_cbc,
    input  logic         cfg_keylen,
    input  logic [255:0] cfg_key,
    input  logic [127:0] cfg_iv,
    output logic         cfg_ready,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,

    output logic         err_timeout,
`ifdef AES_SEQ_BLKCNT_EN
    output logic [31:0]  blk_cnt,
`endif

    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_ecb_cbc,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_iv,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_KW1,
        S_KW,
        S_READY,
        S_NX,
        S_BW1,
        S_BW,
        S_OUT
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [TO_W-1:0] to_cnt;
    logic [127:0]    iv_shadow;
    logic [127:0]    chain;
    logic [127:0]    blk;
    logic            last_q;

    logic            cfg_load;
    logic            accept;
    logic            capture;
    logic            out_done;
    logic            wait_state;
    logic            to_hit;
    logic            timeout;

    // Configuration is only honoured when no block is in flight.
    assign cfg_load   = cfg_start && (state == S_IDLE || state == S_READY);
    assign accept     = (state == S_READY) && !cfg_start && in_valid;
    assign capture    = (state == S_BW) && core_ready;
    assign out_done   = (state == S_OUT) && out_ready;
    assign wait_state = (state == S_KW1) || (state == S_KW) ||
                        (state == S_BW1) || (state == S_BW);
    assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign in_ready   = (state == S_READY);
    assign core_iv    = chain;
    assign core_block = blk;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cfg_start) next_state = S_INIT;
            end
            S_INIT:  next_state = S_KW1;
            // The core only drops ready one edge after init/next, so its ready is stale here.
            S_KW1:   next_state = S_KW;
            S_KW: begin
                if (core_ready) begin
                    next_state = S_READY;
                end else if (to_hit) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end
            end
            S_READY: begin
                if (cfg_start)     next_state = S_INIT;
                else if (in_valid) next_state = S_NX;
            end
            S_NX:    next_state = S_BW1;
            S_BW1:   next_state = S_BW;
            S_BW: begin
                if (core_ready) begin
                    next_state = S_OUT;
                end else if (to_hit) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) next_state = S_READY;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Timeout counter restarts on every state change and only advances while waiting on the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (next_state != state) begin
            to_cnt <= '0;
        end else if (wait_state) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready <= 1'b0;
            core_init <= 1'b0;
            core_next <= 1'b0;
        end else begin
            cfg_ready <= (next_state == S_READY);
            core_init <= (next_state == S_INIT);
            core_next <= (next_state == S_NX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_encdec  <= 1'b0;
            core_ecb_cbc <= 1'b0;
            core_keylen  <= 1'b0;
            core_key     <= '0;
            iv_shadow    <= '0;
            err_timeout  <= 1'b0;
        end else if (cfg_load) begin
            core_encdec  <= cfg_encdec;
            core_ecb_cbc <= cfg_ecb_cbc;
            core_keylen  <= cfg_keylen;
            core_key     <= cfg_key;
            iv_shadow    <= cfg_iv;
            err_timeout  <= 1'b0;
        end else if (timeout) begin
            err_timeout  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk    <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            blk    <= in_data;
            last_q <= in_last;
        end
    end

    // Chaining value: ciphertext feeds forward on both directions; a closed message restores the IV.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else if (cfg_load) begin
            chain <= cfg_iv;
        end else if (capture) begin
            if (last_q) begin
                chain <= iv_shadow;
            end else if (core_ecb_cbc) begin
                chain <= core_encdec ? core_result : blk;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= core_result;
            out_last  <= last_q;
        end else if (out_done) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AES_SEQ_BLKCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= '0;
        end else if (cfg_load) begin
            blk_cnt <= '0;
        end else if (capture) begin
            blk_cnt <= blk_cnt + 32'd1;
        end else if (out_done && out_last) begin
            blk_cnt <= '0;
        end
    end
`endif

endmodule

// File: doc/aes_cbc_stream_seq.md
Name: aes_cbc_stream_seq

Overview:
- Streaming front-end that sits directly upstream of aes_core and owns its control/data ports.
- Loads key, IV and mode, runs key expansion, then accepts 128-bit blocks over a valid/ready input stream.
- Issues one core operation per block, maintains the CBC chaining value across blocks and returns results on a valid/ready output stream.
- Framing is per message: in_last closes a message and restores the configured IV.

Parameters:
- TIMEOUT_CYCLES, 1023: max cycles waiting on core_ready (key or block) before flagging err_timeout.
- TO_W, 10: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse: latch cfg_* and start key expansion
- cfg_encdec  in  1  1=encrypt, 0=decrypt
- cfg_ecb_cbc  in  1  0=ECB, 1=CBC
- cfg_keylen  in  1  0=AES-128, 1=AES-256
- cfg_key  in  256  key; AES-128 uses [255:128]
- cfg_iv  in  128  initial vector
- cfg_ready  out  1  key expanded; stream port idle
- in_valid / in_ready  in/out  1  input handshake
- in_data  in  128  input block
- in_last  in  1  last block of message
- out_valid / out_ready  out/in  1  output handshake
- out_data  out  128  result block
- out_last  out  1  copy of in_last for this block
- err_timeout  out  1  sticky; cleared by cfg_start
- core_init, core_next  out  1  one-cycle pulses to core
- core_encdec, core_ecb_cbc, core_keylen  out  1  registered cfg copies
- core_key  out  256  registered key
- core_iv  out  128  chaining register
- core_block  out  128  latched input block
- core_ready  in  1  core ready
- core_result  in  128  core result (valid while core_ready=1 after an operation)

Behaviour:
- Reset: state=IDLE; every output register is 0, including cfg_ready, in_ready, out_valid, out_data, out_last, err_timeout, core_init and core_next; chain and shadow IV are 0.
- IDLE: cfg_start -> latch cfg_* into core-facing registers; iv_shadow and chain <= cfg_iv; clear err_timeout; -> INIT.
- INIT: core_init=1 for exactly one cycle -> KW1.
- KW1: one dead cycle, core_ready ignored because the core drops ready one edge after init -> KW.
- KW: when core_ready=1 -> READY with cfg_ready=1.
- READY: in_ready=1 (combinational from state).
  - On in_valid&in_ready: blk <= in_data, last_q <= in_last -> NX.
  - cfg_start here restarts at IDLE-latch behaviour; it takes priority over a simultaneous input handshake, which is not accepted.
- NX: core_next=1 for exactly one cycle -> BW1.
- BW1: one dead cycle -> BW.
- BW: when core_ready=1:
  - Capture out_data <= core_result, out_last <= last_q, out_valid <= 1.
  - Chain update, same edge: CBC encrypt -> chain <= core_result; CBC decrypt -> chain <= blk; ECB -> unchanged.
  - If last_q=1, chain <= iv_shadow instead (overrides the update above).
  - -> OUT.
- OUT: hold out_data/out_last stable while out_valid & !out_ready. On out_ready -> out_valid <= 0 -> READY.
- Latency: input accept to out_valid = 4 + core latency cycles. No overlap: one block in flight.
- core_block and core_iv are stable from NX through the BW capture edge. The core XORs the IV combinationally on both the input and output sides, so this stability is required.
- Timeout: counter runs in KW1/KW/BW1/BW and resets on every state entry.
  - When it reaches TIMEOUT_CYCLES: err_timeout=1, -> IDLE, cfg_ready=0.
  - Subsequent inputs are blocked (in_ready=0) until the next cfg_start.
- cfg_start in INIT/KW1/KW/NX/BW1/BW/OUT: ignored.
- Reset mid-operation: asynchronous return to reset values; any pending output is discarded.

Optional Feature:
- Macro AES_SEQ_BLKCNT_EN.
- Defined: adds output port blk_cnt [31:0].
  - Increments when BW captures a result; wraps 0xFFFFFFFF -> 0.
  - Clears on cfg_start and on the output handshake of an out_last=1 block.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ECB-128 encrypt, key 000102..0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1; core_init and core_next are each exactly one cycle high.
- CBC-128 encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102..0f:
  - in 6bc1bee22e409f96e93d7e117393172a -> out 7649abac8119b246cee98e9b12e9197d.
  - then ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> out 5086cb9b507219ee95db113a917678b2.
- CBC decrypt of those two ciphertexts with the same key and iv -> both plaintexts back; after last, core_iv = 000102..0f. Repeat the message and get an identical result.
- Backpressure: out_ready=0 for 20 cycles -> out_valid stays 1, out_data is stable and in_ready=0 throughout; on release the next block is accepted.
- Timeout with a core model holding core_ready=0 and TIMEOUT_CYCLES=15 -> err_timeout=1 after 15 cycles in BW, state IDLE, in_ready=0; the next cfg_start clears the flag.
- Reset asserted in BW -> all outputs 0 immediately. With AES_SEQ_BLKCNT_EN defined, blk_cnt=0 after reset and reads 1 then 2 during the CBC test.
